tim_apb_arb: RTL and testbench
==============================

TIM_APB_ARB -- requirements
Module: tim_apb_arb

Interface
REQ-001 Parameter ADDR_W, default 8, is the width of the APB address forwarded to the timer block.
REQ-002 Parameter DATA_W, default 32, is the width of the write and read data.
REQ-003 pclk  input  1  sole clock; every register samples on its rising edge.
REQ-004 presetn  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  transfer request from requester 0 and 1; held high until the matching done.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; stable while the matching req is high.
REQ-007 addr0, addr1  input  ADDR_W each  register address; stable while the matching req is high.
REQ-008 wdata0, wdata1  input  DATA_W each  write data; stable while the matching req is high.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 rdata0, rdata1  output  DATA_W each  read data returned to each requester.
REQ-011 psel, penable, pwrite  output  1 each  APB control driven to the timer block.
REQ-012 paddr  output  ADDR_W  APB address.
REQ-013 pwdata  output  DATA_W  APB write data.
REQ-014 prdata  input  DATA_W  APB read data from the timer block; the block has no pready and is always zero-wait.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-016 IDLE: when an eligible request exists, the arbiter SHALL register the winner's we, addr and wdata into pwrite, paddr and pwdata, assert psel, and go to SETUP.
REQ-017 SETUP: psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-018 ACCESS: psel=1 and penable=1 for exactly one cycle, then go to IDLE with psel=0 and penable=0.
REQ-019 At the end of ACCESS, done of the granted requester SHALL be 1 during the following cycle only.
REQ-020 At the end of ACCESS, for a read, prdata SHALL be captured into that requester's rdata; rdata SHALL hold until that requester's next read completes.
REQ-021 Writes SHALL leave both rdata outputs unchanged.
REQ-022 Eligible means req_k=1 and done_k=0 in the same cycle, so a requester dropping req on its done is never granted twice.
REQ-023 A single eligible requester SHALL win immediately.
REQ-024 When both are eligible, the winner SHALL be the requester not granted last (round-robin).
REQ-025 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-026 Minimum transfer period is 3 cycles (IDLE, SETUP, ACCESS); there SHALL be no idle gap beyond the IDLE cycle when a request is pending.
REQ-027 paddr, pwrite and pwdata SHALL stay constant from SETUP through ACCESS.
REQ-028 A requester dropping req during SETUP or ACCESS SHALL NOT abort the transfer; its done is still issued.
REQ-029 Request inputs are registered only in IDLE; changes to them during SETUP or ACCESS SHALL have no effect on the transfer in progress.

Reset
REQ-030 presetn low SHALL immediately force the state to IDLE and set psel, penable, pwrite, done0 and done1 to 0.
REQ-031 presetn low SHALL clear paddr, pwdata, rdata0 and rdata1 to 0 and set last-grant to 1.
REQ-032 A reset during SETUP or ACCESS SHALL abandon the transfer with no done pulse.
REQ-033 Deassertion of presetn SHALL be synchronised to pclk outside this block.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the default widths ADDR_W=8 and DATA_W=32.
REQ-035 The block SHALL be a single module with no sub-modules; the round-robin select is small enough to stay inline.
REQ-036 All outputs SHALL be driven directly from flops, with no combinational path from the req inputs to the APB outputs.

Verification
REQ-037 Single write: req0=1, we0=1, addr0=8'h08, wdata0=32'h0000_1234 -> cycle+1 psel=1, penable=0, paddr=8'h08, pwdata=32'h1234; cycle+2 penable=1; cycle+3 done0=1 and psel=0.
REQ-038 Read: req1 read of addr 8'h04 with prdata=32'hDEAD_BEEF during ACCESS -> done1=1 and rdata1=32'hDEADBEEF; rdata0 unchanged.
REQ-039 Simultaneous requests after reset: req0 and req1 both high and held -> grant order 0, 1, 0, 1; each transfer is 3 cycles and each done is a single cycle.
REQ-040 Drop on done: req0 drops on its done while req1 is high -> next grant goes to 1; requester 0 is never granted a second time.
REQ-041 Reset in ACCESS: presetn low for 1 cycle during ACCESS -> psel=0 and penable=0 at once, no done, rdata cleared to 0, and requester 0 wins the next tie.
REQ-042 Stability: randomise addr and wdata during SETUP and ACCESS -> paddr and pwdata keep the values registered in IDLE.

Source files
------------

// File: rtl/tim_apb_arb_pkg.sv
// Shared definitions for the two-requester APB arbiter: FSM encoding and default widths.
package tim_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_e;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/tim_apb_arb.sv
// Two-requester round-robin arbiter in front of a zero-wait APB timer block.
// Every output comes straight from a flop; request inputs are sampled only in IDLE.
module tim_apb_arb
    import tim_apb_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata
);

    state_e              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    // Requester granted most recently; also selects done/rdata routing for the transfer in flight.
    logic                last_q, last_d;

    logic                elig0, elig1, win;

    // Next-state, arbitration and output-register logic.
    always_comb begin
        // A requester whose done is high this cycle is dropping req; never re-grant it.
        elig0     = req0 & ~done0_q;
        elig1     = req1 & ~done1_q;
        // Tie goes to whoever was not granted last.
        win       = (elig0 & elig1) ? ~last_q : elig1;

        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        last_d    = last_q;

        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    last_d   = win;
                    pwrite_d = win ? we1    : we0;
                    paddr_d  = win ? addr1  : addr0;
                    pwdata_d = win ? wdata1 : wdata0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (last_q) begin
                    done1_d = 1'b1;
                    if (!pwrite_q) rdata1_d = prdata;
                end else begin
                    done0_d = 1'b1;
                    if (!pwrite_q) rdata0_d = prdata;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer without a done pulse.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            last_q    <= last_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_tim_apb_arb.sv
// Bench for tim_apb_arb: directed scenarios plus randomized traffic checked against
// a transfer-level reference model.
module tb_tim_apb_arb;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [1:0]  rq, wq;
    logic [7:0]  aq [2];
    logic [31:0] dq [2];
    logic [31:0] prdata;
    logic        done0, done1, psel, penable, pwrite;
    logic [31:0] rdata0, rdata1, pwdata;
    logic [7:0]  paddr;

    int n_cmp = 0;
    int n_err = 0;

    tim_apb_arb #(.ADDR_W(8), .DATA_W(32)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
        .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    // Reference model: one transfer record (who, fields, age since grant) plus
    // the round-robin history and the per-requester done/rdata views.
    logic        m_act, m_who, m_last, m_we;
    int          m_age;
    logic [7:0]  m_addr;
    logic [31:0] m_wd;
    logic        m_done [2];
    logic [31:0] m_rd [2];

    always @(posedge pclk or negedge presetn) begin
        logic e [2];
        if (!presetn) begin
            m_act = 0; m_age = 0; m_who = 0; m_last = 1; m_we = 0;
            m_addr = '0; m_wd = '0;
            m_done[0] = 0; m_done[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
        end else begin
            for (int k = 0; k < 2; k++) e[k] = rq[k] && !m_done[k];
            m_done[0] = 0; m_done[1] = 0;
            if (!m_act) begin
                if (e[0] || e[1]) begin
                    m_who  = (e[0] && e[1]) ? !m_last : e[1];
                    m_last = m_who;
                    m_act  = 1; m_age = 0;
                    m_we   = wq[m_who]; m_addr = aq[m_who]; m_wd = dq[m_who];
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else begin
                m_act = 0;
                m_done[m_who] = 1;
                if (!m_we) m_rd[m_who] = prdata;
            end
        end
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge pclk) begin
        chk("m_psel",    psel,    m_act);
        chk("m_penable", penable, m_act && m_age == 1);
        chk("m_pwrite",  pwrite,  m_we);
        chk("m_paddr",   paddr,   m_addr);
        chk("m_pwdata",  pwdata,  m_wd);
        chk("m_done0",   done0,   m_done[0]);
        chk("m_done1",   done1,   m_done[1]);
        chk("m_rdata0",  rdata0,  m_rd[0]);
        chk("m_rdata1",  rdata1,  m_rd[1]);
    end

    initial begin
        presetn = 0; rq = '0; wq = '0; prdata = '0;
        aq[0] = '0; aq[1] = '0; dq[0] = '0; dq[1] = '0;
        repeat (2) tick();
        chk("rst_psel", psel, 0); chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0); chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0); chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0); chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        presetn = 1;
        tick();

        // Single write from requester 0.
        rq[0] = 1; wq[0] = 1; aq[0] = 8'h08; dq[0] = 32'h0000_1234;
        tick();
        chk("wr_setup_psel", psel, 1); chk("wr_setup_pen", penable, 0);
        chk("wr_paddr", paddr, 8'h08); chk("wr_pwdata", pwdata, 32'h1234);
        chk("wr_pwrite", pwrite, 1);
        tick();
        chk("wr_acc_psel", psel, 1); chk("wr_acc_pen", penable, 1);
        tick();
        chk("wr_done0", done0, 1); chk("wr_end_psel", psel, 0);
        chk("wr_done1", done1, 0);
        rq[0] = 0;
        tick();
        chk("wr_done0_pulse", done0, 0);

        // Read from requester 1.
        rq[1] = 1; wq[1] = 0; aq[1] = 8'h04; prdata = 32'hDEAD_BEEF;
        tick(); tick(); tick();
        chk("rd_done1", done1, 1); chk("rd_rdata1", rdata1, 32'hDEADBEEF);
        chk("rd_rdata0", rdata0, 0);
        rq[1] = 0;
        tick();

        // Reset while in ACCESS: requester 0 wins since 1 was granted last.
        rq = 2'b11; wq[0] = 1; aq[0] = 8'h10; dq[0] = 32'hA5A5_0001;
        wq[1] = 0; aq[1] = 8'h20;
        tick();
        chk("rst_acc_paddr", paddr, 8'h10);
        tick();
        chk("rst_acc_pen", penable, 1);
        presetn = 0;
        #1;
        chk("rst_acc_psel0", psel, 0); chk("rst_acc_pen0", penable, 0);
        chk("rst_acc_rdata1", rdata1, 0); chk("rst_acc_done0", done0, 0);
        tick();
        presetn = 1;
        chk("rst_acc_nodone0", done0, 0); chk("rst_acc_nodone1", done1, 0);

        // Both held after reset: grants alternate 0,1,0,1, 3 cycles each.
        tick();
        for (int g = 0; g < 4; g++) begin
            chk("rr_setup_paddr", paddr, (g % 2) ? 8'h20 : 8'h10);
            chk("rr_setup_pen", penable, 0); chk("rr_setup_psel", psel, 1);
            tick();
            chk("rr_acc_pen", penable, 1);
            tick();
            chk("rr_done_win", (g % 2) ? done1 : done0, 1);
            chk("rr_done_other", (g % 2) ? done0 : done1, 0);
            chk("rr_end_psel", psel, 0);
            if (g < 3) tick();
        end
        rq = 2'b00;
        tick();
        chk("rr_idle_psel", psel, 0);

        // Requester 0 drops on its done while 1 waits.
        rq = 2'b11;
        tick();
        chk("drop_g0", paddr, 8'h10);
        tick(); tick();
        chk("drop_done0", done0, 1);
        rq[0] = 0;
        tick();
        chk("drop_g1", paddr, 8'h20); chk("drop_g1_psel", psel, 1);
        tick(); tick();
        chk("drop_done1", done1, 1);
        rq[1] = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_no_regrant", psel, 0);
        end

        // Randomized traffic, including field churn and req drops mid-transfer.
        for (int c = 0; c < 2000; c++) begin
            presetn = 1;
            prdata = $urandom;
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 ? done0 : done1) && rq[k]) begin
                    if ($urandom_range(1, 0) == 0) rq[k] = 0;
                    else begin
                        wq[k] = $urandom_range(1, 0); aq[k] = $urandom; dq[k] = $urandom;
                    end
                end else if (!rq[k] && $urandom_range(9, 0) < 4) begin
                    rq[k] = 1; wq[k] = $urandom_range(1, 0); aq[k] = $urandom; dq[k] = $urandom;
                end
                if (psel) begin
                    if ($urandom_range(9, 0) < 3) begin
                        wq[k] = $urandom_range(1, 0); aq[k] = $urandom; dq[k] = $urandom;
                    end
                    if ($urandom_range(19, 0) == 0) rq[k] = 0;
                end
            end
            if ($urandom_range(299, 0) == 0) presetn = 0;
            tick();
        end
        presetn = 1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
